// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready arbiter for one shared combinational ALU
// Round-robin by default; ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_srca,
  output logic [WIDTH-1:0]  alu_srcb,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;

  logic               can_accept;
  logic               grant_valid;
  logic               grant_id;
  logic               transfer;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic               prio_q, prio_d;
`endif

  // The output register can take a new result when empty or being drained now.
  assign can_accept = (state_q == EMPTY) || rsp_ready;

  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = prio_q;
`endif
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign transfer   = grant_valid && can_accept;
  assign req0_ready = transfer && !grant_id;
  assign req1_ready = transfer && grant_id;

  // The ALU sees the granted operands even while stalled, so its result is ready on release.
  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = '0;
    if (grant_valid) begin
      if (grant_id) begin
        alu_srca = req1_a;
        alu_srcb = req1_b;
        alu_ctrl = req1_ctrl;
      end else begin
        alu_srca = req0_a;
        alu_srcb = req0_b;
        alu_ctrl = req0_ctrl;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      EMPTY: begin
        if (transfer) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (!transfer && rsp_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (transfer) begin
      rsp_id_d     = grant_id;
      rsp_result_d = alu_result;
      rsp_zero_d   = alu_zero;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Priority only rotates on an accepted operation; stalled requests keep their turn.
  always_comb begin
    prio_d = prio_q;
    if (transfer) begin
      prio_d = ~grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a small ALU attached
module tb_alu_arbiter;

  localparam int WIDTH  = 32;
  localparam int CTRL_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [WIDTH-1:0]  req0_a, req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              req1_valid, req1_ready;
  logic [WIDTH-1:0]  req1_a, req1_b;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [WIDTH-1:0]  alu_srca, alu_srcb;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [WIDTH-1:0]  rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_srca & alu_srcb;
      3'b001:  alu_result = alu_srca | alu_srcb;
      3'b010:  alu_result = alu_srca + alu_srcb;
      3'b110:  alu_result = alu_srca - alu_srcb;
      3'b111:  alu_result = {31'b0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .alu_srca   (alu_srca),
    .alu_srcb   (alu_srcb),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic id,
                           input logic [31:0] res, input logic z);
    chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'(v));
    chk({tag, ".rsp_id"},     32'(rsp_id),     32'(id));
    chk({tag, ".rsp_result"}, rsp_result,      res);
    chk({tag, ".rsp_zero"},   32'(rsp_zero),   32'(z));
  endtask

  task automatic set_contention();
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 3'b110;
    req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_ctrl = 3'b010;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_rsp("reset", 1'b0, 1'b0, 32'd0, 1'b0);

    // Single op: 5 + 3 from requester 0
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b010;
    #1;
    chk("single.req0_ready", 32'(req0_ready), 32'd1);
    chk("single.req1_ready", 32'(req1_ready), 32'd0);
    chk("single.alu_srca",   alu_srca,        32'd5);
    tick();
    req0_valid = 1'b0;
    check_rsp("single", 1'b1, 1'b0, 32'd8, 1'b0);
    tick();
    chk("single.drain", 32'(rsp_valid), 32'd0);

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin contention from reset: 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_contention();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d.req0_ready", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d.req1_ready", i), 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d.alu_srca", i),   alu_srca,        (i % 2 == 0) ? 32'd7 : 32'd2);
      tick();
      if (i % 2 == 0) check_rsp($sformatf("rr%0d", i), 1'b1, 1'b0, 32'd0, 1'b1);
      else            check_rsp($sformatf("rr%0d", i), 1'b1, 1'b1, 32'd4, 1'b0);
    end

    // Backpressure after first transfer; prio must still favour requester 1
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    set_contention();
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rsp($sformatf("bp%0d", i), 1'b1, 1'b0, 32'd0, 1'b1);
      chk($sformatf("bp%0d.req0_ready", i), 32'(req0_ready), 32'd0);
      chk($sformatf("bp%0d.req1_ready", i), 32'(req1_ready), 32'd0);
      chk($sformatf("bp%0d.alu_srca", i),   alu_srca,        32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.release.req1_ready", 32'(req1_ready), 32'd1);
    chk("bp.release.req0_ready", 32'(req0_ready), 32'd0);
    tick();
    check_rsp("bp.release", 1'b1, 1'b1, 32'd4, 1'b0);

    // Idle drive and drain
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle.alu_srca",   alu_srca,        32'd0);
    chk("idle.alu_srcb",   alu_srcb,        32'd0);
    chk("idle.alu_ctrl",   32'(alu_ctrl),   32'd0);
    chk("idle.req0_ready", 32'(req0_ready), 32'd0);
    chk("idle.req1_ready", 32'(req1_ready), 32'd0);
    tick();
    chk("idle.drain", 32'(rsp_valid), 32'd0);

    // Reset while a stalled response is pending
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 3'b010;
    tick();
    check_rsp("rstmid.pre", 1'b1, 1'b0, 32'd8, 1'b0);
    set_contention();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_rsp("rstmid.post", 1'b0, 1'b0, 32'd0, 1'b0);
    rsp_ready = 1'b1;
    #1;
    chk("rstmid.grant.req0_ready", 32'(req0_ready), 32'd1);
    chk("rstmid.grant.req1_ready", 32'(req1_ready), 32'd0);
    tick();
    check_rsp("rstmid.grant", 1'b1, 1'b0, 32'd0, 1'b1);
`else
    // Fixed priority: requester 0 wins every cycle
    set_contention();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("fp%0d.req0_ready", i), 32'(req0_ready), 32'd1);
      chk($sformatf("fp%0d.req1_ready", i), 32'(req1_ready), 32'd0);
      tick();
      check_rsp($sformatf("fp%0d", i), 1'b1, 1'b0, 32'd0, 1'b1);
    end
`endif

    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU (SrcA/SrcB/ALUControl in, ALUResult/Zero out) between two requesters, e.g. the main datapath and a branch/address-compute unit.
- Each requester uses a valid/ready handshake.
- The arbiter drives the shared ALU's inputs, registers the result and Zero, and returns them on one response port tagged with the requester id.
- Round-robin arbitration; one operation accepted per cycle.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 3, ALU control width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  requester 0 SrcA
- req0_b  in  WIDTH  requester 0 SrcB
- req0_ctrl  in  CTRL_W  requester 0 ALUControl
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0, for requester 1
- alu_srca  out  WIDTH  to shared ALU SrcA
- alu_srcb  out  WIDTH  to shared ALU SrcB
- alu_ctrl  out  CTRL_W  to shared ALU ALUControl
- alu_result  in  WIDTH  from shared ALU ALUResult
- alu_zero  in  1  from shared ALU Zero
- rsp_valid  out  1  registered response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  WIDTH  registered ALUResult
- rsp_zero  out  1  registered Zero

Behaviour:
- Reset (sync, active-high, dominates everything):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - Priority pointer prio=0 (requester 0 favoured).
  - Any pending response is discarded, including a reset that arrives while rsp_valid=1.
- can_accept = !rsp_valid || rsp_ready (output register empty or draining this cycle).
- Grant (combinational):
  - Only one reqN_valid high -> grant N.
  - Both high -> grant prio.
  - Neither high -> no grant.
- reqN_ready = can_accept && grant==N. Ready may depend on valid; requesters must not make valid depend on ready.
- ALU drive (combinational):
  - Grant present -> alu_srca/alu_srcb/alu_ctrl = granted requester's a/b/ctrl. This holds even when can_accept=0.
  - No grant -> all driven 0.
- Transfer occurs when reqN_valid && reqN_ready in cycle t:
  - At the edge ending t, capture rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=N, rsp_valid<=1.
  - Latency is 1 cycle: the response is visible in t+1.
- Response drain: rsp_valid && rsp_ready with no new transfer -> rsp_valid<=0.
- Same-cycle drain plus new transfer -> rsp_valid stays 1 and the register loads the new result. Full throughput of 1 op/cycle while rsp_ready=1.
- Stall: rsp_valid && !rsp_ready -> both req_ready=0; rsp_* hold stable until accepted.
- Priority update: only on a transfer, prio <= ~granted_id. With no transfer, prio is unchanged, including when a request was stalled.
- Requester rules: a requester holding valid without ready must keep a/b/ctrl stable. The arbiter does not check this.
- States:
  - EMPTY (rsp_valid=0) -> FULL on transfer.
  - FULL -> EMPTY on drain without transfer.
  - FULL -> FULL on stall, or on drain with transfer.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both valid; prio register is absent; requester 1 can starve.
- Undefined: round-robin as above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
The bench attaches the team ALU (ALUControl 3'b010=add, 3'b110=sub).
- Single op: req0 a=5, b=3, ctrl=010, rsp_ready=1 -> req0_ready=1 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8, rsp_zero=0.
- Contention round-robin: both valid every cycle; req0 7-7 sub, req1 2+2 add; rsp_ready=1 -> grants alternate 0,1,0,1 from reset. Responses are (id0, 0, zero=1), (id1, 4, zero=0), repeating.
- Backpressure: rsp_ready=0 after the first transfer -> rsp_* hold the first result for 4 cycles, both req_ready=0, prio unchanged. Raising rsp_ready -> a new transfer in the same cycle, rsp_valid stays 1.
- Idle drive: no valid -> alu_srca=0, alu_srcb=0, alu_ctrl=0, req_ready=0, rsp_valid falls after drain.
- Reset mid-operation: rsp_valid=1, rsp_ready=0, assert reset 1 cycle -> rsp_valid=0, rsp_result=0, next contention grants requester 0.
- ALU_ARB_FIXED_PRIO_EN build: both valid continuously for 5 cycles -> all 5 grants to requester 0, req1_ready=0 throughout.
